half_period_meter: RTL and testbench

- Receive-side counterpart of the team's clock divider: takes a square wave (e.g. a divided clock or external tone) and measures the spacing between its edges in `clk` cycles.
- Reports the value as the divider's `freq` encoding: edges every F+1 cycles measure as F.
- Used for self-check of generated tones and for reading back an external rate.
- Includes an input synchronizer, a small FSM, a lock detector and a timeout.

---
 rtl/half_period_meter.sv | 143 ++++++++++++++
 tb/tb_half_period_meter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/half_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : half_period_meter
// Brief    : Measures the spacing between edges of an asynchronous square wave
//            in clk cycles, reported in the clock divider's freq encoding
//            (edge spacing minus one), with lock detection and a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module half_period_meter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] TIMEOUT     = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sig_in,
  output logic [31:0] freq_out,
  output logic        valid,
  output logic        locked,
  output logic        timeout
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sig_s;
  logic                   sig_edge;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [31:0] freq_q;
  logic [31:0] freq_d;
  logic [31:0] last_q;
  logic [31:0] last_d;
  logic        have_last_q;
  logic        have_last_d;
  logic        valid_q;
  logic        valid_d;
  logic        locked_q;
  logic        locked_d;
  logic        timeout_q;
  logic        timeout_d;

  // Both edge polarities count; the fixed pipeline delay keeps spacing intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sig_s;
    end
  end

  assign sig_s    = sync_q[SYNC_STAGES-1];
  assign sig_edge = sig_s ^ prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      freq_q      <= '0;
      last_q      <= '0;
      have_last_q <= 1'b0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      freq_q      <= freq_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    freq_d      = freq_q;
    last_d      = last_q;
    have_last_d = have_last_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;

    if (!en) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      locked_d    = 1'b0;
      have_last_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (sig_edge) begin
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          // An edge landing exactly on the timeout count is still a measurement.
          if (sig_edge) begin
            freq_d      = cnt_q;
            valid_d     = 1'b1;
            timeout_d   = 1'b0;
            last_d      = cnt_q;
            locked_d    = (cnt_q == last_q) && have_last_q;
            have_last_d = 1'b1;
            cnt_d       = '0;
          end else if (cnt_q == TIMEOUT) begin
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            have_last_d = 1'b0;
            cnt_d       = '0;
            state_d     = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign freq_out = freq_q;
  assign valid    = valid_q;
  assign locked   = locked_q;
  assign timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_half_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_half_period_meter
// Brief    : Scoreboard bench for half_period_meter; sig_in is toggled from the
//            bench like a divider output and expected reports are queued.
// Revision : 1.0 - initial release
// ============================================================================
module tb_half_period_meter;

  localparam int unsigned c_sync = 2;
  localparam int          c_tmo  = 100;
  localparam int          c_lat  = c_sync + 1;

  typedef struct {
    logic [31:0] f;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sig_in;
  logic [31:0] freq_out;
  logic        valid;
  logic        locked;
  logic        timeout;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic        obs_v;
  logic        obs_l;
  logic        obs_t;
  logic [31:0] obs_f;

  half_period_meter #(
    .SYNC_STAGES(c_sync),
    .TIMEOUT    (32'(c_tmo))
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sig_in  (sig_in),
    .freq_out(freq_out),
    .valid   (valid),
    .locked  (locked),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // One cycle: sample outputs away from posedge, then drive the next inputs.
  task automatic cyc(input logic tog, input logic en_v, input logic rst_v);
    @(negedge clk);
    obs_v = valid;
    obs_f = freq_out;
    obs_l = locked;
    obs_t = timeout;
    if (tog) sig_in = ~sig_in;
    en  = en_v;
    rst = rst_v;
  endtask

  task automatic settle();
    cyc(1'b0, 1'b0, 1'b0);
    sig_in = 1'b0;
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] f, input logic l);
    exp_t e;
    e.f = f;
    e.l = l;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    n_chk += 4;
    if (obs_f !== 32'd0) begin n_fail++; $display("FAIL reset_freq: got %0d, want 0", obs_f); end
    if (obs_v !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b, want 0", obs_v); end
    if (obs_l !== 1'b0)  begin n_fail++; $display("FAIL reset_locked: got %b, want 0", obs_l); end
    if (obs_t !== 1'b0)  begin n_fail++; $display("FAIL reset_timeout: got %b, want 0", obs_t); end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_divider();
    exp_t e;
    logic tog;
    settle();
    for (int i = 0; i < 36; i++) begin
      tog = (i % 5 == 0) && (i <= 30);
      if (tog && i >= 5) push(32'd4, i >= 10);
      cyc(tog, 1'b1, 1'b0);
      if (obs_v) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL divider_extra_valid: freq_out=%0d, want no valid", obs_f);
        end else begin
          e = sb.pop_front();
          if (obs_f !== e.f || obs_l !== e.l || obs_t !== 1'b0) begin
            n_fail++; $display("FAIL divider_result: freq=%0d locked=%b timeout=%b, want %0d %b 0", obs_f, obs_l, obs_t, e.f, e.l);
          end
        end
      end
    end
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL divider_missing_valid: %0d pending, want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_freq_change();
    exp_t e;
    logic tog;
    settle();
    for (int i = 0; i < 46; i++) begin
      tog = (i == 0) || (i == 5) || (i == 10) || (i == 20) || (i == 30) || (i == 40);
      if (i == 5)  push(32'd4, 1'b0);
      if (i == 10) push(32'd4, 1'b1);
      if (i == 20) push(32'd9, 1'b0);
      if (i == 30) push(32'd9, 1'b1);
      if (i == 40) push(32'd9, 1'b1);
      cyc(tog, 1'b1, 1'b0);
      if (obs_v) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL freqchg_extra_valid: freq_out=%0d, want no valid", obs_f);
        end else begin
          e = sb.pop_front();
          if (obs_f !== e.f || obs_l !== e.l || obs_t !== 1'b0) begin
            n_fail++; $display("FAIL freqchg_result: freq=%0d locked=%b timeout=%b, want %0d %b 0", obs_f, obs_l, obs_t, e.f, e.l);
          end
        end
      end
    end
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL freqchg_missing_valid: %0d pending, want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_timeout();
    exp_t e;
    logic tog;
    int   to_at;
    to_at = 108 + c_lat + c_tmo + 1;
    settle();
    for (int i = 0; i < to_at + 18; i++) begin
      tog = (i == 0) || (i == 101) || (i == 108) || (i == to_at + 4) || (i == to_at + 9);
      if (i == 101)        push(32'(c_tmo), 1'b0);
      if (i == 108)        push(32'd6, 1'b0);
      if (i == to_at + 9)  push(32'd4, 1'b0);
      cyc(tog, 1'b1, 1'b0);
      if (obs_v) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL timeout_extra_valid: freq_out=%0d, want no valid", obs_f);
        end else begin
          e = sb.pop_front();
          if (obs_f !== e.f || obs_l !== e.l || obs_t !== 1'b0) begin
            n_fail++; $display("FAIL timeout_result: freq=%0d locked=%b timeout=%b, want %0d %b 0", obs_f, obs_l, obs_t, e.f, e.l);
          end
        end
      end
      if (i == to_at - 1) begin
        n_chk++;
        if (obs_t !== 1'b0) begin n_fail++; $display("FAIL timeout_early: timeout=%b, want 0", obs_t); end
      end
      if (i == to_at) begin
        n_chk++;
        if (obs_t !== 1'b1 || obs_f !== 32'd6 || obs_l !== 1'b0) begin
          n_fail++; $display("FAIL timeout_set: timeout=%b freq=%0d locked=%b, want 1 6 0", obs_t, obs_f, obs_l);
        end
      end
      if (i == to_at + 8) begin
        n_chk++;
        if (obs_t !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky_after_arm: timeout=%b, want 1", obs_t); end
      end
      if (i == to_at + 17) begin
        n_chk++;
        if (obs_t !== 1'b0) begin n_fail++; $display("FAIL timeout_cleared: timeout=%b, want 0", obs_t); end
      end
    end
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL timeout_missing_valid: %0d pending, want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_rst_mid();
    exp_t e;
    logic tog;
    settle();
    // Two edges before the reset leave sig_in low, so reset creates no edge.
    for (int i = 0; i < 26; i++) begin
      tog = (i == 0) || (i == 6) || (i == 14) || (i == 20);
      if (i == 6)  push(32'd5, 1'b0);
      if (i == 20) push(32'd5, 1'b0);
      cyc(tog, 1'b1, i == 10);
      if (obs_v) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rstmid_extra_valid: freq_out=%0d, want no valid", obs_f);
        end else begin
          e = sb.pop_front();
          if (obs_f !== e.f || obs_l !== e.l || obs_t !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_result: freq=%0d locked=%b timeout=%b, want %0d %b 0", obs_f, obs_l, obs_t, e.f, e.l);
          end
        end
      end
      if (i == 11) begin
        n_chk++;
        if (obs_f !== 32'd0 || obs_v !== 1'b0 || obs_l !== 1'b0 || obs_t !== 1'b0) begin
          n_fail++; $display("FAIL rstmid_cleared: freq=%0d valid=%b locked=%b timeout=%b, want all 0", obs_f, obs_v, obs_l, obs_t);
        end
      end
    end
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL rstmid_missing_valid: %0d pending, want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_en_gap();
    exp_t e;
    logic tog;
    int   k;
    settle();
    for (int i = 0; i < 29; i++) begin
      tog = (i % 3 == 0) && (i <= 24);
      k   = i / 3;
      if (tog && (k == 1 || k == 6)) push(32'd2, 1'b0);
      if (tog && (k == 2 || k == 3 || k == 7 || k == 8)) push(32'd2, 1'b1);
      cyc(tog, !(i >= 12 && i <= 14), 1'b0);
      if (obs_v) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL engap_extra_valid: freq_out=%0d, want no valid", obs_f);
        end else begin
          e = sb.pop_front();
          if (obs_f !== e.f || obs_l !== e.l || obs_t !== 1'b0) begin
            n_fail++; $display("FAIL engap_result: freq=%0d locked=%b timeout=%b, want %0d %b 0", obs_f, obs_l, obs_t, e.f, e.l);
          end
        end
      end
      if (i == 13) begin
        n_chk++;
        if (obs_l !== 1'b0 || obs_f !== 32'd2) begin
          n_fail++; $display("FAIL engap_disabled: locked=%b freq=%0d, want 0 2", obs_l, obs_f);
        end
      end
    end
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL engap_missing_valid: %0d pending, want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic tog;
    settle();
    for (int i = 0; i < 25; i++) begin
      tog = (i < 20);
      if (tog && i >= 1) push(32'd0, i >= 2);
      cyc(tog, 1'b1, 1'b0);
      if (obs_v) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_valid: freq_out=%0d, want no valid", obs_f);
        end else begin
          e = sb.pop_front();
          if (obs_f !== e.f || obs_l !== e.l || obs_t !== 1'b0) begin
            n_fail++; $display("FAIL b2b_result: freq=%0d locked=%b timeout=%b, want %0d %b 0", obs_f, obs_l, obs_t, e.f, e.l);
          end
        end
      end
      if (i == 12) begin
        n_chk++;
        if (obs_v !== 1'b1) begin n_fail++; $display("FAIL b2b_continuous_valid: valid=%b, want 1", obs_v); end
      end
    end
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_missing_valid: %0d pending, want 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    sig_in = 1'b0;
    test_reset();
    test_divider();
    test_freq_change();
    test_timeout();
    test_rst_mid();
    test_en_gap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
